// File: rtl/a3_pe_sequencer.sv
// Four-phase schedule wrapper around one a3 biquad PE, with a small result FIFO.
// Latency: accept -> result at out_valid is 4*HOLD+1 cycles; one accept every 4*HOLD+1 cycles.
// Backpressure: in_ready drops while a sample is in flight or the result FIFO is full.
//
// Ports:
//   clk, rst              clock (rising edge) and asynchronous active-low reset
//   in_data/valid/ready   upstream sample handshake
//   out_data/valid/ready  downstream result handshake (FIFO head)
//   pe_in, pe_ber         registered drive to the PE; pe_out is the PE result
//   busy                  a sample is being sequenced
// Optional: define A3_SEQ_STAT_EN to add sample_cnt (saturating capture count)
// and drop_flag (sticky: an offer was blocked by a full FIFO).
module a3_pe_sequencer #(
    parameter int HOLD       = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] pe_in,
    output logic [1:0]  pe_ber,
    input  logic [31:0] pe_out,
    output logic        busy
`ifdef A3_SEQ_STAT_EN
    ,
    output logic [15:0] sample_cnt,
    output logic        drop_flag
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_FB   = 3'd2;
    localparam logic [2:0] S_FF   = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    localparam int PW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(HOLD - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [31:0]   sample_q, sample_d;
    logic [31:0]   pe_in_q, pe_in_d;
    logic [1:0]    pe_ber_q, pe_ber_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [31:0]   mem_d [FIFO_DEPTH];

    logic phase_last, fifo_full, accept, push, pop;

    assign phase_last = (phase_q == PH_LAST);
    assign fifo_full  = (count_q == DEPTH_C);
    // Gated with rst so upstream never sees ready while the block is held in reset.
    assign in_ready   = rst && (state_q == S_IDLE) && !fifo_full;
    assign accept     = in_valid && in_ready;
    // Capture on the final OUT cycle; room was reserved at accept time.
    assign push       = (state_q == S_OUT) && phase_last;
    assign out_valid  = (count_q != '0);
    assign pop        = out_valid && out_ready;
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign pe_in      = pe_in_q;
    assign pe_ber     = pe_ber_q;
    assign busy       = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)     state_d = S_LOAD;
            S_LOAD:  if (phase_last) state_d = S_FB;
            S_FB:    if (phase_last) state_d = S_FF;
            S_FF:    if (phase_last) state_d = S_OUT;
            S_OUT:   if (phase_last) state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase

        // Counter runs only while sequencing and restarts at every phase change.
        phase_d  = (state_q != S_IDLE && !phase_last) ? phase_q + 1'b1 : '0;
        sample_d = accept ? in_data : sample_q;

        // PE drive follows the next state so it changes on the same edge.
        pe_in_d = '0;
        case (state_d)
            S_LOAD:  begin pe_ber_d = 2'b11; pe_in_d = sample_d; end
            S_FB:    pe_ber_d = 2'b00;
            S_FF:    pe_ber_d = 2'b01;
            S_OUT:   pe_ber_d = 2'b10;
            default: pe_ber_d = 2'b11;
        endcase

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = pe_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            phase_q  <= '0;
            sample_q <= '0;
            pe_in_q  <= '0;
            pe_ber_q <= 2'b11;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            sample_q <= sample_d;
            pe_in_q  <= pe_in_d;
            pe_ber_q <= pe_ber_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

`ifdef A3_SEQ_STAT_EN
    logic [15:0] sample_cnt_q, sample_cnt_d;
    logic        drop_flag_q, drop_flag_d;

    always_comb begin
        sample_cnt_d = (push && sample_cnt_q != 16'hFFFF) ? sample_cnt_q + 16'd1 : sample_cnt_q;
        drop_flag_d  = drop_flag_q | ((state_q == S_IDLE) && in_valid && fifo_full);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_cnt_q <= '0;
            drop_flag_q  <= 1'b0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            drop_flag_q  <= drop_flag_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
    assign drop_flag  = drop_flag_q;
`endif

endmodule

// File: tb/tb_a3_pe_sequencer.sv
// Bench for a3_pe_sequencer: timeline model of the sample schedule plus FIFO queue,
// compared every cycle, with directed scenarios and literal spot checks.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_a3_pe_sequencer;

    localparam int HOLD  = 3;
    localparam int DEPTH = 4;
    localparam int SPAN  = 4 * HOLD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] pe_in;
    logic [1:0]  pe_ber;
    logic [31:0] pe_out = '0;
    logic        busy;
`ifdef A3_SEQ_STAT_EN
    logic [15:0] sample_cnt;
    logic        drop_flag;
`endif

    a3_pe_sequencer #(.HOLD(HOLD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .pe_in(pe_in), .pe_ber(pe_ber), .pe_out(pe_out), .busy(busy)
`ifdef A3_SEQ_STAT_EN
        , .sample_cnt(sample_cnt), .drop_flag(drop_flag)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // A sample accepted on edge E occupies the SPAN cycles after E; elapsed cycle d
    // selects phase d/HOLD.  Its result is pe_out on the last of those cycles.
    int unsigned cyc   = 0;
    int unsigned t_acc = 0;
    bit          active = 1'b0;
    logic [31:0] m_sample = '0;
    logic [31:0] mq [$];
    int unsigned m_cnt = 0;
    bit          m_drop = 1'b0;

    always @(posedge clk or negedge rst) begin : model
        bit          cap, pop, acc;
        int unsigned d;
        if (!rst) begin
            active = 1'b0;
            mq.delete();
            m_cnt  = 0;
            m_drop = 1'b0;
            m_sample = '0;
        end else begin
            d   = cyc - t_acc;
            cap = active && (d == SPAN - 1);
            pop = out_ready && (mq.size() > 0);
            acc = in_valid && !active && (mq.size() < DEPTH);
            if (in_valid && !active && mq.size() == DEPTH) m_drop = 1'b1;
            if (pop) void'(mq.pop_front());
            if (cap) begin
                mq.push_back(pe_out);
                active = 1'b0;
                if (m_cnt < 65535) m_cnt++;
            end
            if (acc) begin
                active   = 1'b1;
                m_sample = in_data;
                t_acc    = cyc + 1;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin : compare
        logic [1:0]  e_ber;
        logic [31:0] e_in;
        int unsigned ph;
        e_ber = 2'b11;
        e_in  = '0;
        if (active) begin
            ph = (cyc - t_acc) / HOLD;
            case (ph)
                0:       begin e_ber = 2'b11; e_in = m_sample; end
                1:       e_ber = 2'b00;
                2:       e_ber = 2'b01;
                default: e_ber = 2'b10;
            endcase
        end
        check("pe_ber",    {30'd0, pe_ber}, {30'd0, e_ber});
        check("pe_in",     pe_in, e_in);
        check("busy",      {31'd0, busy}, {31'd0, active});
        check("in_ready",  {31'd0, in_ready}, {31'd0, (rst && !active && mq.size() < DEPTH)});
        check("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
        check("out_data",  out_data, (mq.size() > 0) ? mq[0] : 32'd0);
`ifdef A3_SEQ_STAT_EN
        check("sample_cnt", {16'd0, sample_cnt}, m_cnt[31:0] & 32'hFFFF);
        check("drop_flag",  {31'd0, drop_flag}, {31'd0, m_drop});
`endif
    end

    // ---------------- varying stimulus source ----------------
    bit vary   = 1'b0;
    bit toggle = 1'b0;
    int unsigned tcyc = 0;
    initial forever begin
        @(posedge clk);
        #1;
        tcyc++;
        if (vary) begin
            pe_out  = 32'hBEEF_0000 | tcyc;
            in_data = 32'h1000_0000 | tcyc;
        end
        if (toggle) out_ready = tcyc[1];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin : main
        int  acc_cnt;
        bit  hit;

        // ---- reset ----
        tick(2);
        @(negedge clk);
        check("rst_in_ready",  {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_pe_ber",    {30'd0, pe_ber}, 32'd3);
        check("rst_pe_in",     pe_in, 32'd0);
        check("rst_out_data",  out_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ---- single sample ----
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 32'h0001_0000;
        pe_out   = 32'h1234_5678;
        @(negedge clk);
        check("single_ready_T", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);                       // T+1
        check("T1_ber", {30'd0, pe_ber}, 32'd3);
        check("T1_in",  pe_in, 32'h0001_0000);
        repeat (3) @(negedge clk);            // T+4
        check("T4_ber", {30'd0, pe_ber}, 32'd0);
        check("T4_in",  pe_in, 32'd0);
        repeat (3) @(negedge clk);            // T+7
        check("T7_ber", {30'd0, pe_ber}, 32'd1);
        repeat (3) @(negedge clk);            // T+10
        check("T10_ber", {30'd0, pe_ber}, 32'd2);
        repeat (2) @(negedge clk);            // T+12
        check("T12_ber",       {30'd0, pe_ber}, 32'd2);
        check("T12_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);                       // T+13
        check("T13_out_valid", {31'd0, out_valid}, 32'd1);
        check("T13_out_data",  out_data, 32'h1234_5678);
        check("T13_ber",       {30'd0, pe_ber}, 32'd3);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("single_popped", {31'd0, out_valid}, 32'd0);

        // ---- backpressure fill: continuous offers, no drain ----
        @(posedge clk); #1;
        vary = 1'b1;
        in_valid = 1'b1;
        acc_cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (in_valid && in_ready) acc_cnt++;
        end
        check("fill_accepts",  acc_cnt, 32'd4);
        check("fill_in_ready", {31'd0, in_ready}, 32'd0);
        check("fill_head",     out_data, (mq.size() > 0) ? mq[0] : 32'hDEAD_DEAD);

        // ---- pop one, then pop exactly on the next capture cycle ----
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(posedge clk); #1;
            if (active && (cyc - t_acc) == SPAN - 1) hit = 1'b1;
        end
        check("cap_cycle_found", {31'd0, hit}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("pushpop_depth", mq.size(), 32'd3);

        // ---- mixed traffic with toggling out_ready ----
        toggle = 1'b1;
        tick(80);
        in_valid = 1'b0;
        tick(15);
        toggle = 1'b0;
        out_ready = 1'b1;
        tick(8);
        out_ready = 1'b0;
        @(negedge clk);
        check("drained", {31'd0, out_valid}, 32'd0);

        // ---- mid-sample reset during FF ----
        @(posedge clk); #1;
        vary = 1'b0;
        in_data = 32'h0000_0ABC;
        pe_out  = 32'h0BAD_0BAD;
        in_valid = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            @(posedge clk); #1;
            if (mq.size() == 1 && active && (cyc - t_acc) == 2 * HOLD) hit = 1'b1;
        end
        check("ff_reached", {31'd0, hit}, 32'd1);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_busy",      {31'd0, busy}, 32'd0);
        check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_pe_ber",    {30'd0, pe_ber}, 32'd3);
        check("mrst_pe_in",     pe_in, 32'd0);
        tick(2);
        rst = 1'b1;
        tick(30);
        @(negedge clk);
        check("no_stale", {31'd0, out_valid}, 32'd0);

`ifdef A3_SEQ_STAT_EN
        // ---- statistics ----
        @(posedge clk); #1;
        vary = 1'b1;
        in_valid = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 60 && !hit; k++) begin
            @(posedge clk); #1;
            if (m_cnt == 3) hit = 1'b1;
        end
        @(negedge clk);
        check("stat_three", {16'd0, sample_cnt}, 32'd3);
        tick(25);
        @(negedge clk);
        check("stat_drop", {31'd0, drop_flag}, 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick(10);
        out_ready = 1'b0;
        @(negedge clk);
        check("stat_drop_sticky", {31'd0, drop_flag}, 32'd1);
        check("stat_four", {16'd0, sample_cnt}, 32'd4);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("stat_drop_rst", {31'd0, drop_flag}, 32'd0);
        check("stat_cnt_rst",  {16'd0, sample_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        tick(2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
